// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the cascaded modulo-N digit counter.
// Direction encoding, legal parameter ranges and the digit width needed for a given modulus.
package cnt_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int MODULUS_MIN = 2;
    localparam int MODULUS_MAX = 16;
    localparam int DIGITS_MIN  = 1;
    localparam int DIGITS_MAX  = 8;

    // Smallest field width whose range 0..2**w-1 covers 0..modulus-1.
    function automatic int digit_width(input int modulus);
        if (modulus <= 2) begin
            return 1;
        end
        return $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_n_digit_counter_digit.sv
// One modulo-MODULUS digit with load, up/down stepping and boundary detect.
// at_bound tells the next digit up the chain that this digit is about to roll over.
module mod_n_digit
    import cnt_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_in,
    input  logic               up_dn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_d,
    output logic [DIGIT_W-1:0] q,
    output logic               at_bound
);

    localparam logic [DIGIT_W:0]   MOD_X = (DIGIT_W + 1)'(MODULUS);
    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MODULUS - 1);
    localparam logic [DIGIT_W-1:0] ONE_V = DIGIT_W'(1);

    logic [DIGIT_W-1:0] r_q;
    logic [DIGIT_W-1:0] w_q_next;
    logic               w_illegal;
    logic               w_load_ok;

    // Compared one bit wider so MODULUS == 2**DIGIT_W does not overflow the constant.
    assign w_illegal = ({1'b0, r_q} >= MOD_X);
    assign w_load_ok = ({1'b0, load_d} < MOD_X);

    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = w_load_ok ? load_d : '0;
        end else if (step_in) begin
            if (w_illegal) begin
                w_q_next = '0;
            end else if (up_dn == DIR_UP) begin
                w_q_next = (r_q == MAX_V) ? '0 : r_q + ONE_V;
            end else begin
                w_q_next = (r_q == '0) ? MAX_V : r_q - ONE_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q        = r_q;
    assign at_bound = (up_dn == DIR_UP) ? (r_q == MAX_V) : (r_q == '0);

endmodule

// File: rtl/mod_n_digit_counter.sv
// NUM_DIGITS cascaded modulo-MODULUS up/down digits with parallel load.
// tc is combinational from en/load/up_dn and state; wrap is the registered tc of the previous edge.
module mod_n_digit_counter
    import cnt_pkg::*;
#(
    parameter int MODULUS    = 10,
    parameter int NUM_DIGITS = 2,
    parameter int DIGIT_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
    output logic [NUM_DIGITS*DIGIT_W-1:0] z,
    output logic                          tc,
    output logic                          wrap
);

    generate
        if (MODULUS < MODULUS_MIN || MODULUS > MODULUS_MAX) begin : g_bad_modulus
            $fatal(1, "mod_n_digit_counter: MODULUS out of range 2..16");
        end
        if (NUM_DIGITS < DIGITS_MIN || NUM_DIGITS > DIGITS_MAX) begin : g_bad_digits
            $fatal(1, "mod_n_digit_counter: NUM_DIGITS out of range 1..8");
        end
        if (DIGIT_W < digit_width(MODULUS)) begin : g_bad_width
            $fatal(1, "mod_n_digit_counter: DIGIT_W too narrow for MODULUS");
        end
    endgenerate

    logic [NUM_DIGITS-1:0] w_step;
    logic [NUM_DIGITS-1:0] w_bound;
    logic                  w_tc;
    logic                  r_wrap;

    // A digit steps only while every lower digit sits at its rollover point.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi = gi + 1) begin : g_digit
            if (gi == 0) begin : g_first
                assign w_step[gi] = en & ~load;
            end else begin : g_chain
                assign w_step[gi] = w_step[gi-1] & w_bound[gi-1];
            end

            mod_n_digit #(
                .MODULUS (MODULUS),
                .DIGIT_W (DIGIT_W)
            ) u_digit (
                .clk      (clk),
                .rst      (rst),
                .step_in  (w_step[gi]),
                .up_dn    (up_dn),
                .load     (load),
                .load_d   (load_val[gi*DIGIT_W +: DIGIT_W]),
                .q        (z[gi*DIGIT_W +: DIGIT_W]),
                .at_bound (w_bound[gi])
            );
        end
    endgenerate

    assign w_tc = w_step[NUM_DIGITS-1] & w_bound[NUM_DIGITS-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrap <= 1'b0;
        end else if (load) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_tc;
        end
    end

    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule
